// File: rtl/core_regfile_sb_pkg.sv
// Shared types for the register file / scoreboard slice.
//   DEF_*      : default geometry (32 x 32-bit registers)
//   reg_index_t: register index at the default geometry
//   word_t     : register word at XLEN=32
//   sb_cmd_e   : per-register pending-counter update for one cycle
package core_regfile_sb_pkg;

   localparam int unsigned DEF_XLEN     = 32;
   localparam int unsigned DEF_NUM_REGS = 32;
   localparam int unsigned DEF_IDX_W    = $clog2(DEF_NUM_REGS);

   typedef logic [DEF_IDX_W-1:0] reg_index_t;
   typedef logic [DEF_XLEN-1:0]  word_t;

   typedef enum logic [1:0] {
      SB_NOP,
      SB_ALLOC,
      SB_RETIRE,
      SB_BOTH
   } sb_cmd_e;

   // Collapse the accepted-alloc / commit hits for one register into a command.
   function automatic sb_cmd_e sb_cmd_f(input logic alloc_hit, input logic wr_hit);
      sb_cmd_e cmd;
      case ({alloc_hit, wr_hit})
         2'b10:   cmd = SB_ALLOC;
         2'b01:   cmd = SB_RETIRE;
         2'b11:   cmd = SB_BOTH;
         default: cmd = SB_NOP;
      endcase
      return cmd;
   endfunction

endpackage

// File: rtl/core_regfile_sb_if.sv
// Decode/writeback bundle of the register file.
//   rd_idx/rd_data/rd_busy       : NUM_RD_PORTS combinational read ports (flattened)
//   alloc_valid/alloc_idx/ready  : destination claim from decode
//   wr_valid/wr_idx/wr_data      : commit from writeback
//   flush                        : squash all in-flight allocations
//   sb_err                       : sticky scoreboard protocol error
// master = pipeline side, slave = register file.
interface core_regfile_sb_if #(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned NUM_REGS     = 32,
   parameter int unsigned NUM_RD_PORTS = 2,
   parameter int unsigned IDX_W        = $clog2(NUM_REGS)
);

   logic [NUM_RD_PORTS*IDX_W-1:0] rd_idx;
   logic [NUM_RD_PORTS*XLEN-1:0]  rd_data;
   logic [NUM_RD_PORTS-1:0]       rd_busy;
   logic                          alloc_valid;
   logic [IDX_W-1:0]              alloc_idx;
   logic                          alloc_ready;
   logic                          wr_valid;
   logic [IDX_W-1:0]              wr_idx;
   logic [XLEN-1:0]               wr_data;
   logic                          flush;
   logic                          sb_err;

   modport master (
      output rd_idx, alloc_valid, alloc_idx, wr_valid, wr_idx, wr_data, flush,
      input  rd_data, rd_busy, alloc_ready, sb_err
   );

   modport slave (
      input  rd_idx, alloc_valid, alloc_idx, wr_valid, wr_idx, wr_data, flush,
      output rd_data, rd_busy, alloc_ready, sb_err
   );

endinterface

// File: rtl/core_regfile_sb_scoreboard.sv
// Per-register pending-write counters.
//   clk, rst                 : clock, async active-high reset
//   alloc_valid/alloc_idx    : destination claim
//   wr_valid/wr_idx          : commit
//   flush                    : clear all counters
//   rd_idx                   : read indices (flattened, one per port)
//   alloc_ready              : alloc_idx counter not saturated (or index 0)
//   sb_err                   : sticky protocol error
//   rd_busy                  : per port, pending != 0
//   rd_busy_multi            : per port, pending > 1 (busy once a same-cycle commit retires one)
module core_regfile_sb_scoreboard
   import core_regfile_sb_pkg::*;
#(
   parameter int unsigned NUM_REGS     = DEF_NUM_REGS,
   parameter int unsigned NUM_RD_PORTS = 2,
   parameter int unsigned PEND_W       = 2,
   parameter int unsigned IDX_W        = $clog2(NUM_REGS)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          alloc_valid,
   input  logic [IDX_W-1:0]              alloc_idx,
   input  logic                          wr_valid,
   input  logic [IDX_W-1:0]              wr_idx,
   input  logic                          flush,
   input  logic [NUM_RD_PORTS*IDX_W-1:0] rd_idx,
   output logic                          alloc_ready,
   output logic                          sb_err,
   output logic [NUM_RD_PORTS-1:0]       rd_busy,
   output logic [NUM_RD_PORTS-1:0]       rd_busy_multi
);

   localparam logic [PEND_W-1:0] PEND_MAX = '1;
   localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

   logic [PEND_W-1:0] pending [NUM_REGS];
   sb_cmd_e           cmd     [NUM_REGS];
   logic              err_set;

   // Readiness looks only at the registered count, never at a same-cycle
   // commit, so there is no path from wr_* to alloc_ready.
   always_comb begin
      alloc_ready = (alloc_idx == '0) || (pending[alloc_idx] != PEND_MAX);
   end

   always_comb begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         cmd[r] = sb_cmd_f(alloc_valid && alloc_ready && (alloc_idx == IDX_W'(r)) && (r != 0),
                           wr_valid && (wr_idx == IDX_W'(r)) && (r != 0));
      end
      // A commit is only an error when it would actually underflow: a same-cycle
      // accepted alloc to the same register cancels it out.
      err_set = (!flush && alloc_valid && !alloc_ready) ||
                ((cmd[wr_idx] == SB_RETIRE) && (pending[wr_idx] == '0));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            pending[r] <= '0;
         end
         sb_err <= 1'b0;
      end else begin
         sb_err <= sb_err | err_set;
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (flush) begin
               pending[r] <= '0;
            end else begin
               case (cmd[r])
                  SB_ALLOC:  pending[r] <= pending[r] + PEND_ONE;
                  SB_RETIRE: if (pending[r] != '0) pending[r] <= pending[r] - PEND_ONE;
                  default:   pending[r] <= pending[r];
               endcase
            end
         end
      end
   end

   always_comb begin
      rd_busy       = '0;
      rd_busy_multi = '0;
      for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
         rd_busy[p]       = pending[rd_idx[p*IDX_W +: IDX_W]] != '0;
         rd_busy_multi[p] = pending[rd_idx[p*IDX_W +: IDX_W]] > PEND_ONE;
      end
   end

endmodule

// File: rtl/core_regfile_sb.sv
// Integer register file with integrated write scoreboard.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of core_regfile_sb_if (read ports, alloc, commit, flush, sb_err)
// Index 0 reads as zero and is never busy. With BYPASS=1 a same-cycle commit
// is forwarded to matching read ports and busy reflects the post-commit count.
module core_regfile_sb
   import core_regfile_sb_pkg::*;
#(
   parameter int unsigned XLEN         = DEF_XLEN,
   parameter int unsigned NUM_REGS     = DEF_NUM_REGS,
   parameter int unsigned NUM_RD_PORTS = 2,
   parameter int unsigned PEND_W       = 2,
   parameter int unsigned BYPASS       = 1
) (
   input  logic              clk,
   input  logic              rst,
   core_regfile_sb_if.slave  bus
);

   localparam int unsigned IDX_W = $clog2(NUM_REGS);

   logic [XLEN-1:0]         regs [NUM_REGS];
   logic [NUM_RD_PORTS-1:0] sb_busy;
   logic [NUM_RD_PORTS-1:0] sb_busy_multi;

   core_regfile_sb_scoreboard #(
      .NUM_REGS     (NUM_REGS),
      .NUM_RD_PORTS (NUM_RD_PORTS),
      .PEND_W       (PEND_W),
      .IDX_W        (IDX_W)
   ) u_scoreboard (
      .clk           (clk),
      .rst           (rst),
      .alloc_valid   (bus.alloc_valid),
      .alloc_idx     (bus.alloc_idx),
      .wr_valid      (bus.wr_valid),
      .wr_idx        (bus.wr_idx),
      .flush         (bus.flush),
      .rd_idx        (bus.rd_idx),
      .alloc_ready   (bus.alloc_ready),
      .sb_err        (bus.sb_err),
      .rd_busy       (sb_busy),
      .rd_busy_multi (sb_busy_multi)
   );

   // Data write is independent of flush and of the scoreboard state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            regs[r] <= '0;
         end
      end else if (bus.wr_valid && (bus.wr_idx != '0)) begin
         regs[bus.wr_idx] <= bus.wr_data;
      end
   end

   always_comb begin
      logic [IDX_W-1:0] idx;
      logic             hit;
      bus.rd_data = '0;
      bus.rd_busy = '0;
      for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
         idx = bus.rd_idx[p*IDX_W +: IDX_W];
         hit = (BYPASS != 0) && bus.wr_valid && (bus.wr_idx == idx) && (idx != '0);
         if (idx == '0) begin
            bus.rd_data[p*XLEN +: XLEN] = '0;
            bus.rd_busy[p]              = 1'b0;
         end else if (hit) begin
            bus.rd_data[p*XLEN +: XLEN] = bus.wr_data;
            bus.rd_busy[p]              = sb_busy_multi[p];
         end else begin
            bus.rd_data[p*XLEN +: XLEN] = regs[idx];
            bus.rd_busy[p]              = sb_busy[p];
         end
      end
   end

endmodule
